// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU control unit between two requesters.
// Optional watchdog is compiled in when ALU_ARB_TIMEOUT_EN is defined.
module alu_arbiter #(
    parameter int unsigned DATA_W      = 8,
`ifdef ALU_ARB_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYC = 64,
`endif
    parameter int unsigned RES_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [1:0]        op0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic              req1,
    input  logic [1:0]        op1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [RES_W-1:0]  result,
    output logic              err,
    output logic              alu_start,
    output logic [1:0]        alu_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_finish,
    input  logic [RES_W-1:0]  alu_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                last_q, last_d;  // last-served requester, doubles as current owner
    logic [1:0]          sel_q, sel_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic                win;
    logic                expired;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                waiting;
    logic                timeout_hit;

    // Leave on the edge at which the count would reach TIMEOUT_CYC.
    assign expired     = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign waiting     = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
    assign timeout_hit = expired &&
                         (((state_q == S_WAIT_BUSY) && alu_finish) ||
                          ((state_q == S_WAIT_DONE) && !alu_finish));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == S_ISSUE) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + 1'b1;
            err_d = timeout_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = (state_q == S_RESP) && err_q;
`else
    assign expired = 1'b0;
    assign err     = 1'b0;
`endif

    // Both requesting: the one not served last; otherwise whichever is asking.
    assign win = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    last_d  = win;
                    sel_d   = win ? op1 : op0;
                    a_d     = win ? a1 : a0;
                    b_d     = win ? b1 : b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!alu_finish) begin
                    state_d = S_WAIT_DONE;
                end else if (expired) begin
                    res_d   = '0;
                    state_d = S_RESP;
                end
            end
            S_WAIT_DONE: begin
                if (alu_finish) begin
                    res_d   = alu_result;
                    state_d = S_RESP;
                end else if (expired) begin
                    res_d   = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign gnt0      = (state_q != S_IDLE) && !last_q;
    assign gnt1      = (state_q != S_IDLE) && last_q;
    assign done0     = (state_q == S_RESP) && !last_q;
    assign done1     = (state_q == S_RESP) && last_q;
    assign alu_start = (state_q == S_ISSUE);
    assign alu_sel   = sel_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign result    = res_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench for alu_arbiter with a behavioural
// ALU control-unit model and a round-robin reference for expected grants and results.
module tb_alu_arbiter;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RES_W  = 16;
    localparam int unsigned BMAX   = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic [1:0]        op0 = '0, op1 = '0;
    logic [DATA_W-1:0] a0 = '0, a1 = '0;
    logic [DATA_W-1:0] b0 = 8'd1, b1 = 8'd1;
    logic              gnt0, gnt1, done0, done1, err, alu_start;
    logic [1:0]        alu_sel;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [RES_W-1:0]  result;
    logic              alu_finish;
    logic [RES_W-1:0]  alu_result;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DATA_W), .RES_W(RES_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .err(err),
        .alu_start(alu_start), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_finish(alu_finish), .alu_result(alu_result)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [RES_W-1:0] alu_fn(input logic [1:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (op)
            2'b00:   return RES_W'(a) + RES_W'(b);
            2'b01:   return RES_W'(a) - RES_W'(b);
            2'b10:   return RES_W'(a) * RES_W'(b);
            default: return {a % b, a / b};
        endcase
    endfunction

    function automatic int exp_winner(input logic r0, input logic r1, input int last);
        if (r0 && r1) return (last == 0) ? 1 : 0;
        return r1 ? 1 : 0;
    endfunction

    // ALU control unit model: finish drops drop_dly cycles after start, rises busy_len later.
    int drop_dly   = 1;
    int busy_len   = 4;
    bit never_drop = 1'b0;
    initial begin
        alu_finish = 1'b1;
        alu_result = '0;
        forever begin
            @(negedge clk);
            if (alu_start === 1'b1 && !never_drop) begin
                logic [RES_W-1:0] r;
                r = alu_fn(alu_sel, alu_a, alu_b);
                repeat (drop_dly) @(negedge clk);
                alu_finish = 1'b0;
                repeat (busy_len) @(negedge clk);
                alu_result = r;
                alu_finish = 1'b1;
            end
        end
    end

    int n_starts = 0, n_gnt1_cyc = 0, n_done0 = 0, n_done1 = 0;
    bit prev_done = 1'b0;
    bit exp_err   = 1'b0;
    always @(negedge clk) begin
        if (alu_start) n_starts++;
        if (gnt1) n_gnt1_cyc++;
        if (done0) n_done0++;
        if (done1) n_done1++;
        if (done0 || done1) begin
            check_val("done_single_cycle", prev_done, 0);
            check_val("done_matches_gnt", {gnt1, gnt0}, {done1, done0});
            check_val("err_with_done", err, exp_err);
        end
        prev_done = done0 || done1;
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic serve(input int exp_who, input bit drop,
                         output int who, output int gnt_lat, output int done_lat);
        bit                ok;
        int                s0;
        logic [1:0]        eop;
        logic [DATA_W-1:0] ea, eb;
        logic [RES_W-1:0]  er;
        s0 = n_starts; who = -1; gnt_lat = 0; done_lat = 0; ok = 1'b0;
        for (int i = 1; i <= 40 && !ok; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin ok = 1'b1; gnt_lat = i; end
        end
        check_val("grant_seen", ok, 1);
        if (!ok) return;
        who = gnt1 ? 1 : 0;
        check_val("grant_winner", who, exp_who);
        check_val("start_with_grant", alu_start, 1);
        if (who == 0) begin eop = op0; ea = a0; eb = b0; end
        else          begin eop = op1; ea = a1; eb = b1; end
        er = alu_fn(eop, ea, eb);
        // Requester changes operands after the grant; these must be ignored.
        if (who == 0) begin
            op0 = 2'($urandom); a0 = DATA_W'($urandom); b0 = DATA_W'($urandom_range(1, BMAX));
            if (drop) req0 = 1'b0;
        end else begin
            op1 = 2'($urandom); a1 = DATA_W'($urandom); b1 = DATA_W'($urandom_range(1, BMAX));
            if (drop) req1 = 1'b0;
        end
        ok = 1'b0;
        for (int i = 1; i <= 200 && !ok; i++) begin
            @(negedge clk);
            if (done0 || done1) begin ok = 1'b1; done_lat = i; end
        end
        check_val("done_seen", ok, 1);
        if (!ok) return;
        check_val("done_owner", {done1, done0}, (who == 1) ? 2'b10 : 2'b01);
        check_val("result", result, er);
        check_val("alu_sel_held", alu_sel, eop);
        check_val("alu_a_held", alu_a, ea);
        check_val("alu_b_held", alu_b, eb);
        check_val("starts_per_txn", n_starts - s0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int who, gl, dl, last_srv, cnt0, cnt1, g1;
        bit ok;
        last_srv = 1;
        repeat (3) @(negedge clk);
        check_val("rst_gnt0", gnt0, 0);
        check_val("rst_gnt1", gnt1, 0);
        check_val("rst_done", {done1, done0}, 0);
        check_val("rst_err", err, 0);
        check_val("rst_start", alu_start, 0);
        check_val("rst_sel", alu_sel, 0);
        check_val("rst_a", alu_a, 0);
        check_val("rst_b", alu_b, 0);
        check_val("rst_result", result, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single add
        g1 = n_gnt1_cyc; cnt1 = n_done1;
        op0 = 2'b00; a0 = 8'd5; b0 = 8'd3; req0 = 1'b1;
        serve(0, 1'b0, who, gl, dl);
        req0 = 1'b0;
        check_val("add_result", result, 16'd8);
        check_val("add_gnt_latency", gl, 1);
        check_val("add_done_latency", dl, 6);
        check_val("add_no_gnt1", n_gnt1_cyc - g1, 0);
        check_val("add_no_done1", n_done1 - cnt1, 0);

        // Simultaneous after reset
        do_reset();
        op0 = 2'b10; a0 = 8'd7;  b0 = 8'd6;
        op1 = 2'b11; a1 = 8'd20; b1 = 8'd3;
        req0 = 1'b1; req1 = 1'b1;
        serve(0, 1'b0, who, gl, dl);
        req0 = 1'b0;
        check_val("simul_mul_result", result, 16'd42);
        serve(1, 1'b0, who, gl, dl);
        check_val("simul_gap", gl, 2);
        check_val("simul_div_a", alu_a, 8'd20);
        check_val("simul_div_sel", alu_sel, 2'b11);
        check_val("simul_div_result", result, {8'd2, 8'd6});
        last_srv = 1;

        // Fairness: both held
        req0 = 1'b1; req1 = 1'b1;
        for (int t = 0; t < 6; t++) begin
            serve(exp_winner(req0, req1, last_srv), 1'b0, who, gl, dl);
            last_srv = who;
        end

        // Random traffic
        for (int t = 0; t < 24; t++) begin
            drop_dly = $urandom_range(1, 3);
            busy_len = $urandom_range(1, 6);
            if ($urandom_range(0, 1) == 1) req0 = 1'b1;
            if ($urandom_range(0, 1) == 1) req1 = 1'b1;
            if (!req0 && !req1) begin
                if ($urandom_range(0, 1) == 1) req0 = 1'b1; else req1 = 1'b1;
            end
            serve(exp_winner(req0, req1, last_srv), ($urandom_range(0, 3) == 0), who, gl, dl);
            last_srv = who;
            if (who == 0) req0 = 1'($urandom_range(0, 1));
            else if (who == 1) req1 = 1'($urandom_range(0, 1));
        end
        req0 = 1'b0; req1 = 1'b0;
        drop_dly = 1; busy_len = 6;
        repeat (2) @(negedge clk);

        // Reset during WAIT_DONE
        op0 = 2'b00; a0 = 8'd9; b0 = 8'd4; req0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (gnt0 && !alu_finish) ok = 1'b1;
        end
        check_val("rmid_busy_seen", ok, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rmid_gnt0", gnt0, 0);
        check_val("rmid_done", {done1, done0}, 0);
        check_val("rmid_start", alu_start, 0);
        check_val("rmid_sel_a_b", {alu_sel, alu_a, alu_b}, 0);
        check_val("rmid_result", result, 0);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt0 = n_done0;
        repeat (10) @(negedge clk);
        check_val("rmid_no_done", n_done0 - cnt0, 0);
        drop_dly = 1; busy_len = 3;
        op1 = 2'b00; a1 = 8'd100; b1 = 8'd27; req1 = 1'b1;
        serve(1, 1'b0, who, gl, dl);
        req1 = 1'b0;
        check_val("rmid_req1_lat", gl, 1);
        check_val("rmid_req1_result", result, 16'd127);
        @(negedge clk);

        // Slow start: finish stays high for 3 cycles after start
        drop_dly = 4; busy_len = 2;
        op0 = 2'b01; a0 = 8'd3; b0 = 8'd10; req0 = 1'b1;
        serve(0, 1'b0, who, gl, dl);
        req0 = 1'b0;
        check_val("slow_done_latency", dl, 7);
        check_val("slow_sub_result", result, 16'hFFF9);
        @(negedge clk);

        // ALU never responds
        never_drop = 1'b1;
`ifdef ALU_ARB_TIMEOUT_EN
        exp_err = 1'b1;
`endif
        op0 = 2'b10; a0 = 8'd11; b0 = 8'd12; req0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (gnt0) ok = 1'b1;
        end
        check_val("to_grant_seen", ok, 1);
        ok = 1'b0; dl = 0;
        for (int i = 1; i <= 100 && !ok; i++) begin
            @(negedge clk);
            if (done0 || done1) begin ok = 1'b1; dl = i; end
        end
`ifdef ALU_ARB_TIMEOUT_EN
        check_val("to_done_seen", ok, 1);
        check_val("to_latency", dl, 65);
        check_val("to_result", result, 0);
        check_val("to_err", err, 1);
`else
        check_val("to_no_done", ok, 0);
        check_val("to_err_zero", err, 0);
`endif
        req0 = 1'b0;
        never_drop = 1'b0;
        exp_err = 1'b0;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
